pulse_sched: RTL
================

# pulse_sched

Round-robin scheduler that shares one strobe source (the single-cycle pulse produced by `clk_pulse` in the fast domain) between several requesters in the USB3300 sniffer. Each requester asks for a burst of N strobes. The block grants one requester at a time and routes exactly N strobes to it. It then signals completion and moves to the next requester. It sits between `clk_pulse` and the consumers that pace their work from the slow-clock edge, such as the serializer and the capture counters.

## Interface
- `N_REQ`, default 4: number of requesters (2–8).
- `LEN_W`, default 8: width of each burst-length field.
- `TIMEOUT`, default 1000: clk cycles with no strobe before a running burst aborts. Used only with `PULSE_SCHED_TIMEOUT_EN`.

- `clk` in 1: fast system clock; everything is synchronous to it.
- `rst` in 1: synchronous, active-high reset.
- `pulse_in` in 1: strobe from `clk_pulse`, high for one clk cycle.
- `req` in N_REQ: level request per requester. Must be held for the whole burst.
- `len` in N_REQ*LEN_W: burst length. Requester i uses bits [i*LEN_W +: LEN_W].
- `grant` out N_REQ: one-hot or zero; the current owner.
- `pulse_out` out N_REQ: strobe routed to the owner only.
- `done` out N_REQ: one-cycle completion flag for the owner.
- `busy` out 1: high while a burst is running.
- `timeout` out 1: one-cycle abort flag. Tied to 0 when the timeout feature is compiled out.

## Operation
- States: IDLE, RUN, DONE.
- Reset values: state IDLE, round-robin pointer `ptr`=0, burst counter 0, and every output 0.
- IDLE:
  - If `req` is nonzero, pick winner g: the first set bit searching ptr, ptr+1, …, wrapping modulo N_REQ.
  - Register `grant`=1<<g, load counter with `len[g]`, set `busy`=1, go to RUN.
  - If `req` is zero, stay in IDLE.
- `len` is sampled only on the IDLE→RUN transition. Later changes are ignored.
- RUN, evaluated in this priority order:
  1. `req[g]`=0 → abort. Clear grant and busy, go to IDLE, set ptr=(g+1) mod N_REQ, no `done`. Any `pulse_in` in the same cycle is dropped.
  2. Counter =0 → go to DONE.
  3. `pulse_in`=1 → assert `pulse_out[g]` next cycle and decrement the counter.
- DONE (exactly one cycle):
  - `done[g]`=1, `grant`=0, `busy`=0.
  - Set ptr=(g+1) mod N_REQ, go to IDLE.
- `len`=0: the burst goes to DONE on the first RUN cycle. No `pulse_out` is issued.
- A `pulse_in` that arrives in IDLE or DONE is discarded; strobes are never queued.
- `pulse_out` never asserts for a requester whose `grant` bit is 0.
- The counter never wraps: it is only decremented when nonzero.
- A requester that keeps `req` high after `done` competes again in the next IDLE, behind every requester between it and ptr.

## Timing
- Grant latency: `req` sampled high at edge t → `grant` high after edge t.
- Strobe latency: `pulse_in` high at edge t (in RUN, counter>0) → `pulse_out[g]` high for one cycle after edge t.
- Completion: the last strobe is counted at edge t.
  - RUN sees counter=0 at edge t+1.
  - `done` is high for the cycle after edge t+1.
  - The earliest next `grant` follows edge t+3 (one IDLE cycle).
- Abort latency: `req[g]` low at edge t → `grant`/`busy` low after edge t.
- Reset asserted mid-burst: all outputs return to 0 after the next edge, with no `done` and no `timeout`. The pointer returns to 0.

## Configuration
- Macro: `PULSE_SCHED_TIMEOUT_EN`.
- When defined:
  - An idle counter clears on entering RUN and on every `pulse_in` in RUN, and increments otherwise.
  - When it reaches `TIMEOUT` in RUN, the burst aborts as for a `req` drop, and `timeout` is high for one cycle.
  - An abort caused by a `req` drop takes priority over a timeout in the same cycle.
- When undefined: no idle counter exists, `timeout` is constant 0, and a burst waits indefinitely for strobes.

## Test plan
- Single requester, len=3, strobes every 7 cycles:
  - `req`=0001 → `grant`=0001 one cycle later.
  - Three `pulse_out[0]`, each one cycle after `pulse_in`.
  - `done`=0001 for one cycle, `busy` falls with `done`.
- Round robin:
  - `req`=1111 held, all len=1, with ptr=0 after reset → grant order 0,1,2,3,0.
  - Every requester receives exactly one strobe per grant.
- len=0 on requester 2: `grant`=0100 for one RUN cycle, then `done`=0100, with zero `pulse_out` even if `pulse_in` is present.
- Abort:
  - Requester 1 with len=5 drops `req` after 2 strobes, in the same cycle as a `pulse_in`.
  - That strobe is not forwarded, no `done`, and the next grant goes to requester 2 if it is requesting.
- Reset mid-burst after 1 of 4 strobes → all outputs 0, and the next grant starts from requester 0.
- With `PULSE_SCHED_TIMEOUT_EN` and TIMEOUT=20: grant requester 3 with no strobes → `timeout` high exactly 20 cycles after RUN entry, `grant`=0, no `done`.

Source files
------------

// File: rtl/pulse_sched.sv
// pulse_sched: round-robin scheduler that hands bursts of N strobes from a
// single pulse source to one requester at a time.
// Optional feature macro: PULSE_SCHED_TIMEOUT_EN (aborts a burst that sees no
// strobe for TIMEOUT cycles; without it the timeout output is tied low).
module pulse_sched #(
    parameter int N_REQ   = 4,
    parameter int LEN_W   = 8,
    parameter int TIMEOUT = 1000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pulse_in,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*LEN_W-1:0] len,
    output logic [N_REQ-1:0]       grant,
    output logic [N_REQ-1:0]       pulse_out,
    output logic [N_REQ-1:0]       done,
    output logic                   busy,
    output logic                   timeout
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    // Reject parameter sets the arbiter and counters were not sized for.
    if (N_REQ < 2 || N_REQ > 8 || LEN_W < 1 || TIMEOUT < 1) begin : g_param_check
        $error("pulse_sched: parameter out of range");
    end

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [N_REQ-1:0]   pulse_out_q, pulse_out_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic               busy_q, busy_d;
    logic               timeout_q, timeout_d;

    logic               win_found;
    logic [PTR_W-1:0]   win_idx;
    logic [PTR_W-1:0]   next_ptr;

`ifdef PULSE_SCHED_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    logic [IDLE_W-1:0]  idle_q, idle_d;
`endif

    // Index base+off wrapped modulo N_REQ.
    function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base,
                                                  input int off);
        int s;
        s = int'(base) + off;
        if (s >= N_REQ) begin
            s = s - N_REQ;
        end
        return PTR_W'(s);
    endfunction

    // Round-robin winner: first requester at or after ptr; scanning from the
    // far end lets the closest match overwrite the others.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[wrap_idx(ptr_q, k)]) begin
                win_found = 1'b1;
                win_idx   = wrap_idx(ptr_q, k);
            end
        end
        next_ptr = wrap_idx(owner_q, 1);
    end

    // Next-state and registered-output logic for the IDLE/RUN/DONE burst FSM.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        grant_d     = grant_q;
        pulse_out_d = '0;
        done_d      = '0;
        busy_d      = busy_q;
        timeout_d   = 1'b0;
`ifdef PULSE_SCHED_TIMEOUT_EN
        idle_d      = idle_q;
`endif
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    owner_d          = win_idx;
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    cnt_d            = len[win_idx*LEN_W +: LEN_W];
                    busy_d           = 1'b1;
                    state_d          = RUN;
`ifdef PULSE_SCHED_TIMEOUT_EN
                    idle_d           = '0;
`endif
                end
            end
            RUN: begin
                if (!req[owner_q]) begin
                    grant_d = '0;
                    busy_d  = 1'b0;
                    ptr_d   = next_ptr;
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    done_d[owner_q] = 1'b1;
                    grant_d         = '0;
                    busy_d          = 1'b0;
                    state_d         = DONE;
                end else if (pulse_in) begin
                    pulse_out_d[owner_q] = 1'b1;
                    cnt_d                = cnt_q - LEN_W'(1);
`ifdef PULSE_SCHED_TIMEOUT_EN
                    idle_d               = '0;
`endif
                end else begin
`ifdef PULSE_SCHED_TIMEOUT_EN
                    if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
                        grant_d   = '0;
                        busy_d    = 1'b0;
                        ptr_d     = next_ptr;
                        timeout_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        idle_d = idle_q + IDLE_W'(1);
                    end
`endif
                end
            end
            DONE: begin
                ptr_d   = next_ptr;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            cnt_q       <= '0;
            grant_q     <= '0;
            pulse_out_q <= '0;
            done_q      <= '0;
            busy_q      <= 1'b0;
            timeout_q   <= 1'b0;
`ifdef PULSE_SCHED_TIMEOUT_EN
            idle_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            grant_q     <= grant_d;
            pulse_out_q <= pulse_out_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            timeout_q   <= timeout_d;
`ifdef PULSE_SCHED_TIMEOUT_EN
            idle_q      <= idle_d;
`endif
        end
    end

    assign grant     = grant_q;
    assign pulse_out = pulse_out_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign timeout   = timeout_q;

endmodule
